// File: rtl/input_conditioner.sv
// Synchronizes and debounces board buttons and switches, and emits one-cycle rise pulses
// that stay suppressed until the inputs have settled after reset.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  input  logic [7:0] sw_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [7:0] sw_level,
  output logic [7:0] sw_rise,
  output logic       any_event,
  output logic       settled
);

  localparam int unsigned NumCh = 13;
  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleEnd = CNT_W'(DEBOUNCE_CYCLES + 1);

  localparam logic [0:0] StSettle = 1'b0;
  localparam logic [0:0] StRun    = 1'b1;

  // Channel map: [4:0] buttons, [12:5] switches.
  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] s1_q, s2_q;
  logic [NumCh-1:0] stable_q, stable_d;
  logic [NumCh-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q [NumCh];
  logic [CNT_W-1:0] cnt_d [NumCh];
  logic             any_q, any_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

  assign raw = {sw_raw, btn_raw};

  always_comb begin
    stable_d = stable_q;
    pulse_d  = '0;
    for (int i = 0; i < NumCh; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LastCnt) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
        pulse_d[i]  = s2_q[i] & (state_q == StRun);
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    // btnS is a game-control button, not a move.
    any_d = |{pulse_d[12:5], pulse_d[3:0]};
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    if (state_q == StSettle) begin
      if (settle_cnt_q == SettleEnd) begin
        state_d = StRun;
      end else begin
        settle_cnt_d = settle_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      pulse_q      <= '0;
      any_q        <= 1'b0;
      state_q      <= StSettle;
      settle_cnt_q <= '0;
      for (int i = 0; i < NumCh; i++) cnt_q[i] <= '0;
    end else begin
      s1_q         <= raw;
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      pulse_q      <= pulse_d;
      any_q        <= any_d;
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      for (int i = 0; i < NumCh; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level = stable_q[4:0];
  assign sw_level  = stable_q[12:5];
  assign btn_press = pulse_q[4:0];
  assign sw_rise   = pulse_q[12:5];
  assign any_event = any_q;
  assign settled   = (state_q == StRun);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4: vector table plus
// hand-written bounce, glitch and mid-debounce reset sequences.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [7:0] sw_raw;
  logic [4:0] btn_level, btn_press;
  logic [7:0] sw_level, sw_rise;
  logic       any_event, settled;

  int errors = 0;
  int checks = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .any_event(any_event),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;
    logic [7:0] sw;
    int         cyc;
    logic [4:0] e_bl;
    logic [4:0] e_bp;
    logic [7:0] e_sl;
    logic [7:0] e_sr;
    logic       e_any;
    logic       e_set;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] bl, input logic [4:0] bp,
                         input logic [7:0] sl, input logic [7:0] sr, input logic an,
                         input logic st);
    chk({tag, ".btn_level"}, 32'(btn_level), 32'(bl));
    chk({tag, ".btn_press"}, 32'(btn_press), 32'(bp));
    chk({tag, ".sw_level"},  32'(sw_level),  32'(sl));
    chk({tag, ".sw_rise"},   32'(sw_rise),   32'(sr));
    chk({tag, ".any_event"}, 32'(any_event), 32'(an));
    chk({tag, ".settled"},   32'(settled),   32'(st));
  endtask

  // Advance n rising edges, then sit 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    //           btn    sw     cyc  bl     bp     sl     sr     any   set
    vecs[0]  = '{5'h00, 8'h05, 5, 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{5'h00, 8'h05, 1, 5'h00, 5'h00, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{5'h00, 8'h05, 3, 5'h00, 5'h00, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{5'h01, 8'h05, 5, 5'h00, 5'h00, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{5'h01, 8'h05, 1, 5'h01, 5'h01, 8'h05, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{5'h01, 8'h05, 1, 5'h01, 5'h00, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{5'h00, 8'h05, 6, 5'h00, 5'h00, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{5'h10, 8'h0D, 5, 5'h00, 5'h00, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{5'h10, 8'h0D, 1, 5'h10, 5'h10, 8'h0D, 8'h08, 1'b1, 1'b1};
    vecs[9]  = '{5'h10, 8'h0D, 1, 5'h10, 5'h00, 8'h0D, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{5'h00, 8'h0D, 6, 5'h00, 5'h00, 8'h0D, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{5'h10, 8'h0D, 5, 5'h00, 5'h00, 8'h0D, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{5'h10, 8'h0D, 1, 5'h10, 5'h10, 8'h0D, 8'h00, 1'b0, 1'b1};
    vecs[13] = '{5'h10, 8'h0D, 1, 5'h10, 5'h00, 8'h0D, 8'h00, 1'b0, 1'b1};

    // Reset with a switch pattern already up.
    rst_n   = 1'b0;
    btn_raw = 5'h00;
    sw_raw  = 8'h05;
    step(3);
    chk_all("reset", 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int v = 0; v < 14; v++) begin
      btn_raw = vecs[v].btn;
      sw_raw  = vecs[v].sw;
      step(vecs[v].cyc);
      chk_all($sformatf("vec%0d", v), vecs[v].e_bl, vecs[v].e_bp, vecs[v].e_sl,
              vecs[v].e_sr, vecs[v].e_any, vecs[v].e_set);
    end

    // Bounce on btnD while btnS stays held: phases 2,1,3,2 clocks, then hold.
    btn_raw = 5'h14; step(1); chk("bounce_p1a", 32'(btn_press[2]), 0);
    step(1);               chk("bounce_p1b", 32'(btn_press[2]), 0);
    btn_raw = 5'h10; step(1); chk("bounce_p2", 32'(btn_press[2]), 0);
    btn_raw = 5'h14;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("bounce_p3", 32'(btn_press[2]), 0);
      chk("bounce_p3_lvl", 32'(btn_level[2]), 0);
    end
    btn_raw = 5'h10;
    for (int k = 0; k < 2; k++) begin
      step(1);
      chk("bounce_p4", 32'(btn_press[2]), 0);
    end
    btn_raw = 5'h14;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk($sformatf("bounce_hold%0d_press", k), 32'(btn_press[2]), 32'(k == 6));
      chk($sformatf("bounce_hold%0d_lvl", k), 32'(btn_level[2]), 32'(k >= 6));
      chk($sformatf("bounce_hold%0d_any", k), 32'(any_event), 32'(k == 6));
    end

    // Three-clock glitch on sw[7] must never be accepted.
    sw_raw = 8'h8D;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("glitch_hi_lvl", 32'(sw_level[7]), 0);
      chk("glitch_hi_rise", 32'(sw_rise[7]), 0);
    end
    sw_raw = 8'h0D;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("glitch_lo_lvl", 32'(sw_level[7]), 0);
      chk("glitch_lo_rise", 32'(sw_rise[7]), 0);
    end

    // Reset while btnR is mid-debounce (counter at 2 after four edges).
    btn_raw = 5'h16;
    step(4);
    chk("midrst_pre_lvl", 32'(btn_level), 32'h14);
    rst_n = 1'b0;
    #1;
    chk_all("midrst_async", 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(2);
    chk_all("midrst_held", 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk_all($sformatf("midrst_settle%0d", k), 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    step(1);
    chk_all("midrst_level", 5'h16, 5'h00, 8'h0D, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk_all("midrst_run", 5'h16, 5'h00, 8'h0D, 8'h00, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
